// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with req/ack memory port, halt and error trap.
// Optional performance counters: define MC_PERF_CNT_EN.
module mc_core_hs #(
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LINK_REG = NREGS - 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc_q,
  output logic [31:0] instr,
  output logic        halted,
  output logic        err,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt,
`endif
  output logic [2:0]  state_q
);

  localparam int RW = $clog2(NREGS);
  localparam logic [RW-1:0] LINK_IDX = RW'(LINK_REG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } st_e;

  st_e         fsm_q, fsm_d;
  logic [31:0] pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic        err_q, err_d;
  logic [31:0] rf_q [NREGS];

  logic          rf_we;
  logic [RW-1:0] rf_wa;
  logic [31:0]   rf_wd;

  logic [5:0]    op, fn;
  logic [RW-1:0] rs, rt, rd;
  logic [31:0]   simm, ea, rres;
  logic          is_r, is_jr, is_alu_r, is_j, is_jal;
  logic          is_beq, is_bne, is_addi, is_lw, is_sw;
  logic          is_halt, illegal;
  logic          unused_ir;

  assign op   = ir_q[31:26];
  assign fn   = ir_q[5:0];
  assign rs   = ir_q[21 +: RW];
  assign rt   = ir_q[16 +: RW];
  assign rd   = ir_q[11 +: RW];
  assign simm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ea   = a_q + simm;
  assign unused_ir = ^ir_q;

  assign is_r     = op == OP_R;
  assign is_jr    = is_r && fn == F_JR;
  assign is_alu_r = is_r && (fn == F_ADD || fn == F_SUB ||
                             fn == F_AND || fn == F_OR  ||
                             fn == F_NOR || fn == F_SLT);
  assign is_j     = op == OP_J;
  assign is_jal   = op == OP_JAL;
  assign is_beq   = op == OP_BEQ;
  assign is_bne   = op == OP_BNE;
  assign is_addi  = op == OP_ADDI;
  assign is_lw    = op == OP_LW;
  assign is_sw    = op == OP_SW;
  assign is_halt  = op == OP_HALT;
  assign illegal  = !(is_alu_r || is_jr || is_j || is_jal ||
                      is_beq || is_bne || is_addi ||
                      is_lw || is_sw || is_halt);

  always_comb begin
    rres = '0;
    unique case (fn)
      F_ADD:   rres = a_q + b_q;
      F_SUB:   rres = a_q - b_q;
      F_AND:   rres = a_q & b_q;
      F_OR:    rres = a_q | b_q;
      F_NOR:   rres = ~(a_q | b_q);
      F_SLT:   rres = {31'b0, $signed(a_q) < $signed(b_q)};
      default: rres = '0;
    endcase
  end

  // Request is combinational so zero-wait memory finishes on the first edge
  // and reset removes it without waiting for a clock.
  assign mem_req   = !reset && (fsm_q == S_FETCH || fsm_q == S_MEM);
  assign mem_we    = !reset && fsm_q == S_MEM && is_sw;
  assign mem_addr  = (fsm_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign instr     = ir_q;
  assign halted    = fsm_q == S_HALT;
  assign err       = err_q;
  assign state_q   = fsm_q;

  always_comb begin
    fsm_d = fsm_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    alu_d = alu_q;
    err_d = err_q;
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    unique case (fsm_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d  = mem_rdata;
          pc_d  = pc_q + 32'd4;
          fsm_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + (simm << 2);
        unique case (1'b1)
          is_j, is_jal: begin
            pc_d  = {pc_q[31:28], ir_q[25:0], 2'b00};
            fsm_d = S_FETCH;
            rf_we = is_jal;
            rf_wa = LINK_IDX;
            rf_wd = pc_q;
          end
          is_jr: begin
            pc_d  = rf_q[rs];
            fsm_d = S_FETCH;
          end
          is_halt: fsm_d = S_HALT;
          illegal: begin
            err_d = 1'b1;
            fsm_d = S_HALT;
          end
          default: fsm_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu_r: begin
            alu_d = rres;
            fsm_d = S_WB;
          end
          is_addi: begin
            alu_d = ea;
            fsm_d = S_WB;
          end
          is_lw, is_sw: begin
            alu_d = ea;
            if (ea[1:0] != 2'b00) begin
              err_d = 1'b1;
              fsm_d = S_HALT;
            end else begin
              fsm_d = S_MEM;
            end
          end
          is_beq, is_bne: begin
            if ((a_q == b_q) == is_beq) pc_d = alu_q;
            fsm_d = S_FETCH;
          end
          default: fsm_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (is_lw) begin
            alu_d = mem_rdata;
            fsm_d = S_WB;
          end else begin
            fsm_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        rf_wa = is_r ? rd : rt;
        rf_wd = alu_q;
        fsm_d = S_FETCH;
      end
      S_HALT:  fsm_d = S_HALT;
      default: fsm_d = S_HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q <= S_FETCH;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      fsm_q <= fsm_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      alu_q <= alu_d;
      err_q <= err_d;
      if (rf_we && rf_wa != '0) rf_q[rf_wa] <= rf_wd;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (fsm_q != S_HALT) cyc_cnt_d = cyc_cnt_q + 32'd1;
    if (fsm_q != S_FETCH && fsm_d == S_FETCH)
      ret_cnt_d = ret_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_core_hs.sv
// Self-checking bench for mc_core_hs: directed programs, ALU vector table,
// randomized ALU programs with wait states, handshake and reset checks.
module tb_mc_core_hs;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_q, instr;
  logic        halted, err;
  logic [2:0]  state_q;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_core_hs dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_q      (pc_q),
    .instr     (instr),
    .halted    (halted),
    .err       (err),
`ifdef MC_PERF_CNT_EN
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
`endif
    .state_q   (state_q)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  int waits = 0;
  int wcnt  = 0;

  // Zero-wait memory holds ack high even when idle.
  assign mem_ack   = (waits == 0) ? 1'b1 : (mem_req && wcnt == waits);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clock) begin
    if (mem_req) begin
      if (mem_ack) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  logic        mon_en = 1'b0;
  logic        pend = 1'b0;
  logic        s_we;
  logic [31:0] s_addr, s_wd;

  always @(negedge clock) begin
    if (mon_en && pend) begin
      total++;
      if (!(mem_req && mem_we == s_we && mem_addr == s_addr &&
            mem_wdata == s_wd)) begin
        bad++;
        $display("FAIL hs_stable req=%b we=%b addr=%h want we=%b addr=%h",
                 mem_req, mem_we, mem_addr, s_we, s_addr);
      end
    end
    pend   = mon_en && mem_req && !mem_ack;
    s_we   = mem_we;
    s_addr = mem_addr;
    s_wd   = mem_wdata;
  end

  function automatic logic [31:0] ri(input logic [5:0] op,
      input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] fn,
      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] op,
      input logic [31:0] a);
    return {op, a[27:2]};
  endfunction

  localparam logic [31:0] HLT = 32'hFC00_0000;

  function automatic logic [31:0] ref_alu(input logic [5:0] fn,
      input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic hold_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic go(input int w);
    waits = w;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    total++;
    if (!halted) begin
      bad++;
      $display("FAIL halt_timeout act=%0d exp=halted", cyc);
    end
  endtask

  task automatic load_alu(input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b);
    mem[0] = ri(6'h23, 5'd1, 5'd0, 16'h0200);
    mem[1] = ri(6'h23, 5'd2, 5'd0, 16'h0204);
    mem[2] = rr(fn, 5'd3, 5'd1, 5'd2);
    mem[3] = ri(6'h2B, 5'd3, 5'd0, 16'h0208);
    mem[4] = HLT;
    mem[128] = a;
    mem[129] = b;
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];
  logic [5:0] fns [6];

  initial begin
    int cyc, n, w;
    logic [31:0] a, b, e;
    logic [5:0] fn;
    logic ok;

    vt[0] = '{6'h20, 32'd5,         32'd7,         32'd12};
    vt[1] = '{6'h20, 32'hFFFF_FFFF, 32'd1,         32'h0};
    vt[2] = '{6'h22, 32'd3,         32'd5,         32'hFFFF_FFFE};
    vt[3] = '{6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vt[4] = '{6'h25, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
    vt[5] = '{6'h27, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vt[6] = '{6'h27, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0};
    vt[7] = '{6'h2A, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vt[8] = '{6'h2A, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vt[9] = '{6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    // reset state and basic program
    hold_reset();
    mem[0] = ri(6'h08, 5'd1, 5'd0, 16'd5);
    mem[1] = ri(6'h08, 5'd2, 5'd0, 16'd7);
    mem[2] = rr(6'h20, 5'd3, 5'd1, 5'd2);
    mem[3] = HLT;
    #1;
    chk("rst_pc", pc_q, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_state", {29'b0, state_q}, 32'd0);
    go(0);
    wait_halt(100, cyc);
    chk("p1_cycles", cyc, 14);
    chk("p1_r3", dut.rf_q[3], 32'd12);
    chk("p1_halted", {31'b0, halted}, 32'd1);
    chk("p1_err", {31'b0, err}, 32'd0);
    chk("p1_pc", pc_q, 32'h10);
    chk("p1_state", {29'b0, state_q}, 32'd5);
    chk("p1_req_off", {31'b0, mem_req}, 32'd0);
`ifdef MC_PERF_CNT_EN
    chk("p1_ret_cnt", ret_cnt, 32'd3);
    chk("p1_cyc_cnt", cyc_cnt, 32'd14);
    repeat (3) @(posedge clock);
    #1;
    chk("p1_cyc_frozen", cyc_cnt, 32'd14);
`endif

    // sw / lw with three wait cycles per access
    hold_reset();
    mem[0] = ri(6'h08, 5'd3, 5'd0, 16'd12);
    mem[1] = ri(6'h2B, 5'd3, 5'd0, 16'h0040);
    mem[2] = ri(6'h23, 5'd4, 5'd0, 16'h0040);
    mem[3] = HLT;
    mon_en = 1'b1;
    go(3);
    wait_halt(200, cyc);
    mon_en = 1'b0;
    chk("ws_cycles", cyc, 33);
    chk("ws_mem40", mem[16], 32'd12);
    chk("ws_r4", dut.rf_q[4], 32'd12);

    // branches
    hold_reset();
    mem[0] = ri(6'h08, 5'd1, 5'd0, 16'd5);
    mem[1] = ri(6'h08, 5'd2, 5'd0, 16'd7);
    mem[2] = ri(6'h05, 5'd2, 5'd1, 16'd2);
    mem[3] = ri(6'h08, 5'd5, 5'd0, 16'd1);
    mem[4] = ri(6'h08, 5'd5, 5'd0, 16'd2);
    mem[5] = ri(6'h04, 5'd2, 5'd1, 16'd1);
    mem[6] = ri(6'h08, 5'd6, 5'd0, 16'd3);
    mem[7] = HLT;
    go(0);
    wait_halt(100, cyc);
    chk("br_cycles", cyc, 20);
    chk("br_skip_r5", dut.rf_q[5], 32'd0);
    chk("br_fall_r6", dut.rf_q[6], 32'd3);
    chk("br_pc", pc_q, 32'h20);

    // jal / jr and r0 write
    hold_reset();
    mem[0]  = jj(6'h03, 32'h100);
    mem[1]  = ri(6'h08, 5'd0, 5'd0, 16'd9);
    mem[2]  = HLT;
    mem[64] = ri(6'h08, 5'd7, 5'd0, 16'd1);
    mem[65] = rr(6'h08, 5'd0, 5'd31, 5'd0);
    go(1);
    wait_halt(200, cyc);
    chk("jl_cycles", cyc, 14 + 5);
    chk("jl_r31", dut.rf_q[31], 32'h4);
    chk("jl_r7", dut.rf_q[7], 32'd1);
    chk("jl_r0", dut.rf_q[0], 32'd0);
    chk("jl_pc", pc_q, 32'hC);
    chk("jl_err", {31'b0, err}, 32'd0);

    // pc wrap from FFFF_FFFC to 0
    hold_reset();
    mem[0]    = ri(6'h05, 5'd0, 5'd2, 16'd2);
    mem[1]    = ri(6'h08, 5'd1, 5'd0, 16'hFFFC);
    mem[2]    = rr(6'h08, 5'd0, 5'd1, 5'd0);
    mem[3]    = HLT;
    mem[1023] = ri(6'h08, 5'd2, 5'd0, 16'd1);
    go(0);
    wait_halt(100, cyc);
    chk("wr_cycles", cyc, 18);
    chk("wr_r1", dut.rf_q[1], 32'hFFFF_FFFC);
    chk("wr_r2", dut.rf_q[2], 32'd1);
    chk("wr_pc", pc_q, 32'h10);

    // misaligned lw traps and stays quiet
    hold_reset();
    mem[0] = ri(6'h23, 5'd4, 5'd0, 16'h0042);
    go(0);
    wait_halt(100, cyc);
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (mem_req || pc_q != 32'h4) ok = 1'b0;
    end
    chk("mis_quiet", {31'b0, ok}, 32'd1);

    // illegal opcode and illegal funct
    hold_reset();
    mem[0] = 32'hF800_0000;
    go(0);
    wait_halt(50, cyc);
    chk("ill_op_err", {31'b0, err}, 32'd1);
    chk("ill_op_cyc", cyc, 2);
    hold_reset();
    mem[0] = rr(6'h00, 5'd1, 5'd0, 5'd0);
    go(2);
    wait_halt(50, cyc);
    chk("ill_fn_err", {31'b0, err}, 32'd1);

    // reset during lw wait
    hold_reset();
    mem[0]  = ri(6'h08, 5'd1, 5'd0, 16'd5);
    mem[1]  = ri(6'h23, 5'd4, 5'd0, 16'h0040);
    mem[2]  = HLT;
    mem[16] = 32'h0000_1234;
    go(5);
    n = 0;
    while (state_q != 3'd3 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("rs_reach_mem", {29'b0, state_q}, 32'd3);
    @(negedge clock);
    chk("rs_req_wait", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rs_pc", pc_q, 32'h0);
    chk("rs_r1", dut.rf_q[1], 32'd0);
    chk("rs_state", {29'b0, state_q}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rs_refetch_req", {31'b0, mem_req}, 32'd1);
    chk("rs_refetch_addr", mem_addr, 32'h0);
    wait_halt(300, cyc);
    chk("rs_r4", dut.rf_q[4], 32'h0000_1234);

    // ALU vector table
    for (int i = 0; i < 10; i++) begin
      hold_reset();
      load_alu(vt[i].fn, vt[i].a, vt[i].b);
      go(0);
      wait_halt(100, cyc);
      chk($sformatf("vec%0d_r3", i), dut.rf_q[3], vt[i].exp);
      chk($sformatf("vec%0d_mem", i), mem[130], vt[i].exp);
    end

    // randomized ALU programs with random wait states
    for (int i = 0; i < 30; i++) begin
      fn = fns[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      w  = $urandom_range(0, 2);
      e  = ref_alu(fn, a, b);
      hold_reset();
      load_alu(fn, a, b);
      go(w);
      wait_halt(200, cyc);
      chk($sformatf("rnd%0d_mem fn=%h", i, fn), mem[130], e);
      chk($sformatf("rnd%0d_cyc w=%0d", i, w), cyc, 20 + 8 * w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
